// File: rtl/crc3_frame_feeder.sv
// Streams a latched message, then zero padding, to a 3-lane parallel CRC core.
// It then waits a bounded time for the remainder and assembles {message, remainder}.
module crc3_frame_feeder #(
   parameter int MSG_W       = 9,
   parameter int LANES       = 3,
   parameter int PAD_BEATS   = 3,
   parameter int REM_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [MSG_W-1:0] msg_in,
   input  logic             msg_valid,
   output logic             msg_ready,
   output logic [LANES-1:0] lane_out,
   output logic             lane_valid,
   output logic             lane_first,
   output logic             lane_last,
   input  logic [8:0]       crc_rem,
   input  logic             crc_rem_valid,
   output logic [MSG_W+8:0] codeword,
   output logic             cw_valid,
   output logic             err_timeout
);

   localparam int DATA_BEATS = MSG_W / LANES;
   localparam int BEAT_W     = $clog2(DATA_BEATS + PAD_BEATS + 1);
   localparam int WAIT_W     = $clog2(REM_TIMEOUT + 1);

   localparam logic [BEAT_W-1:0] LAST_DATA = BEAT_W'(DATA_BEATS - 1);
   localparam logic [BEAT_W-1:0] LAST_PAD  = BEAT_W'(PAD_BEATS - 1);
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(REM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PAD,
      WAIT_REM,
      DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [BEAT_W-1:0]  r_beat_cnt;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic [MSG_W-1:0]   r_msg;
   logic [MSG_W-1:0]   r_shift;
   logic [MSG_W+8:0]   r_codeword;
   logic               w_accept;
   logic               w_capture;
   logic               w_timeout;

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: every output and the next state get a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      msg_ready   = 1'b0;
      lane_out    = '0;
      lane_valid  = 1'b0;
      lane_first  = 1'b0;
      lane_last   = 1'b0;
      cw_valid    = 1'b0;
      err_timeout = 1'b0;

      case (r_state)
         IDLE: begin
            msg_ready = 1'b1;
            if (msg_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            lane_out   = r_shift[MSG_W-1 -: LANES];
            lane_valid = 1'b1;
            lane_first = (r_beat_cnt == '0);
            if (r_beat_cnt == LAST_DATA) begin
               w_state_nxt = PAD;
            end
         end
         PAD: begin
            lane_valid = 1'b1;
            lane_last  = (r_beat_cnt == LAST_PAD);
            if (r_beat_cnt == LAST_PAD) begin
               w_state_nxt = WAIT_REM;
            end
         end
         WAIT_REM: begin
            // A remainder on the expiry cycle still wins over the timeout.
            if (crc_rem_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = DONE;
            end else if (r_wait_cnt == LAST_WAIT) begin
               w_timeout   = 1'b1;
               err_timeout = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         DONE: begin
            cw_valid    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: the payload registers carry a reset because codeword must read 0 out of reset; a true memory array would not.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_beat_cnt <= '0;
         r_wait_cnt <= '0;
         r_msg      <= '0;
         r_shift    <= '0;
         r_codeword <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_msg      <= msg_in;
                  r_shift    <= msg_in;
                  r_beat_cnt <= '0;
               end
            end
            DATA: begin
               r_shift    <= r_shift << LANES;
               r_beat_cnt <= (r_beat_cnt == LAST_DATA) ? '0 : r_beat_cnt + 1'b1;
            end
            PAD: begin
               r_beat_cnt <= (r_beat_cnt == LAST_PAD) ? '0 : r_beat_cnt + 1'b1;
               r_wait_cnt <= '0;
            end
            WAIT_REM: begin
               if (w_capture) begin
                  r_codeword <= {r_msg, crc_rem};
               end
               r_wait_cnt <= (w_capture || w_timeout) ? '0 : r_wait_cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign codeword = r_codeword;

endmodule

// File: doc/crc3_frame_feeder.md
CRC3_FRAME_FEEDER -- requirements
Module: crc3_frame_feeder

Interface
REQ-001 Parameter MSG_W, default 9: message width in bits; SHALL be a multiple of LANES.
REQ-002 Parameter LANES, default 3: bits per beat, matching the 3-parallel CRC core.
REQ-003 Parameter PAD_BEATS, default 3: zero beats appended; PAD_BEATS*LANES equals the polynomial degree (9, for 1+y+y8+y9).
REQ-004 Parameter REM_TIMEOUT, default 8: maximum cycles spent waiting for the remainder.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port msg_in, input, MSG_W bits: message word.
REQ-008 Port msg_valid, input, 1 bit: msg_in is valid.
REQ-009 Port msg_ready, output, 1 bit: the block can accept a message.
REQ-010 Port lane_out, output, LANES bits: beat to the CRC core; lane_out[LANES-1] is the earliest bit.
REQ-011 Port lane_valid, output, 1 bit: lane_out is valid.
REQ-012 Port lane_first, output, 1 bit: marks the first beat of a frame.
REQ-013 Port lane_last, output, 1 bit: marks the last beat (final pad beat).
REQ-014 Port crc_rem, input, 9 bits: remainder returned by the CRC core.
REQ-015 Port crc_rem_valid, input, 1 bit: crc_rem is valid.
REQ-016 Port codeword, output, MSG_W+9 bits: assembled {message, remainder}.
REQ-017 Port cw_valid, output, 1 bit: one-cycle pulse; codeword is valid.
REQ-018 Port err_timeout, output, 1 bit: one-cycle pulse; the remainder did not arrive in time.

Function
REQ-019 States SHALL be IDLE, DATA, PAD, WAIT_REM and DONE.
REQ-020 msg_ready SHALL be 1 only in IDLE; a message is accepted on an edge where msg_valid=1 and msg_ready=1, msg_in is latched, and the next state is DATA.
REQ-021 DATA SHALL last MSG_W/LANES cycles; beat k drives lane_out=msg[MSG_W-1-LANES*k -: LANES] with lane_valid=1.
REQ-022 lane_first SHALL be 1 on DATA beat 0 only.
REQ-023 PAD SHALL last PAD_BEATS cycles with lane_out=0 and lane_valid=1; lane_last=1 on the final PAD beat only.
REQ-024 lane_valid SHALL be contiguous for MSG_W/LANES+PAD_BEATS cycles, with no gaps.
REQ-025 After the final PAD beat the state SHALL be WAIT_REM, with the wait counter cleared.
REQ-026 In WAIT_REM, crc_rem_valid=1 SHALL latch codeword={msg, crc_rem} and move to DONE.
REQ-027 In WAIT_REM without crc_rem_valid, the counter SHALL increment; after REM_TIMEOUT cycles without crc_rem_valid, err_timeout SHALL pulse for one cycle, the state SHALL return to IDLE, and cw_valid SHALL stay 0.
REQ-028 A remainder arriving on the same cycle the counter expires SHALL be accepted, taking priority over the timeout.
REQ-029 In DONE, cw_valid=1 for exactly one cycle, then IDLE; codeword SHALL hold its value until the next capture.
REQ-030 crc_rem_valid outside WAIT_REM SHALL be ignored.
REQ-031 msg_valid outside IDLE SHALL be ignored, with no effect on the frame in flight.
REQ-032 Latency: message accepted at edge E; first beat in the cycle after E; last beat at E+MSG_W/LANES+PAD_BEATS cycles; with a remainder on the first WAIT_REM cycle, cw_valid in the following cycle.
REQ-033 Back-to-back: msg_ready SHALL reassert in the cycle after DONE or after the timeout.

Reset
REQ-034 On reset low, state=IDLE; msg_ready=1 once the state is IDLE; lane_out=0, lane_valid=0, lane_first=0, lane_last=0, codeword=0, cw_valid=0, err_timeout=0; all counters 0.
REQ-035 Reset asserted mid-frame SHALL abort immediately; no cw_valid and no err_timeout SHALL follow release.
REQ-036 After reset release, the block SHALL accept a message in the first cycle that msg_valid=1.

Verification
REQ-037 msg_in=9'b101011010 -> lane_out 101, 011, 010, 000, 000, 000 on six consecutive cycles; lane_first on beat 1 only; lane_last on beat 6 only.
REQ-038 Same frame, crc_rem=9'h0A5 on the 2nd WAIT_REM cycle -> codeword=18'h2B4A5 with a one-cycle cw_valid pulse, then msg_ready=1.
REQ-039 No crc_rem_valid after the frame -> err_timeout pulse exactly REM_TIMEOUT=8 cycles into WAIT_REM; cw_valid stays 0.
REQ-040 crc_rem_valid=1 on the 8th WAIT_REM cycle -> codeword captured and no err_timeout.
REQ-041 msg_valid held high during DATA with a different msg_in, and crc_rem_valid pulsed during PAD -> both ignored; beats unchanged.
REQ-042 reset pulled low on PAD beat 2 -> all outputs at reset values asynchronously, before the next clock edge; a new frame after release is correct.
